// File: rtl/enemy_pkg.sv
// enemy_pkg
//   Shared types and widths for the enemy formation logic.
//   state_e  : formation FSM states (IDLE, MARCH, CLEARED, LANDED)
//   X_OFF_W  : width of the signed horizontal formation offset
//   Y_OFF_W  : width of the unsigned vertical formation offset
//   EDGE_W   : width of the signed arithmetic used for edge tests
package enemy_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MARCH   = 2'd1,
    CLEARED = 2'd2,
    LANDED  = 2'd3
  } state_e;

  localparam int X_OFF_W = 11;
  localparam int Y_OFF_W = 10;
  localparam int EDGE_W  = 12;

endpackage

// File: rtl/alive_extent.sv
// alive_extent
//   Combinational summary of a column-alive vector.
//   col_alive_i : bit c set = column c still has a live enemy
//   low_idx_o   : index of the lowest set bit (0 when none set)
//   high_idx_o  : index of the highest set bit (0 when none set)
//   count_o     : number of set bits
//   any_o       : at least one bit set
module alive_extent
  import enemy_pkg::*;
#(
  parameter int num_cols_p = 8,
  parameter int IDX_W      = (num_cols_p > 1) ? $clog2(num_cols_p) : 1,
  parameter int CNT_W      = $clog2(num_cols_p + 1)
) (
  input  logic [num_cols_p-1:0] col_alive_i,
  output logic [IDX_W-1:0]      low_idx_o,
  output logic [IDX_W-1:0]      high_idx_o,
  output logic [CNT_W-1:0]      count_o,
  output logic                  any_o
);

  // Scan downward for the lowest index and upward for the highest so
  // the last assignment in each loop wins.
  always_comb begin
    low_idx_o  = '0;
    high_idx_o = '0;
    count_o    = '0;
    for (int c = num_cols_p - 1; c >= 0; c--) begin
      if (col_alive_i[c]) low_idx_o = IDX_W'(c);
    end
    for (int c = 0; c < num_cols_p; c++) begin
      if (col_alive_i[c]) high_idx_o = IDX_W'(c);
      count_o = count_o + CNT_W'(col_alive_i[c]);
    end
  end

  assign any_o = |col_alive_i;

endmodule

// File: rtl/enemy_formation_ctrl.sv
// enemy_formation_ctrl
//   Sequences the formation march: horizontal steps, edge drops with
//   direction reversal, and a step tempo that speeds up as columns die.
//   clk_i, reset_i   : clock, synchronous active-high reset
//   start_i          : pulse; starts/restarts a wave outside MARCH
//   pause_i          : level; freezes frame counter and motion
//   frame_i          : pulse once per video frame
//   col_alive_i      : per-column alive flags
//   x_off_o, y_off_o : shared formation offsets (x signed, y unsigned)
//   dir_o            : 1 = moving right
//   step_o, drop_o   : one-cycle motion pulses
//   landed_o, all_dead_o, marching_o : FSM status levels
module enemy_formation_ctrl
  import enemy_pkg::*;
#(
  parameter int num_cols_p       = 8,
  parameter int col_pitch_p      = 40,
  parameter int col_width_p      = 24,
  parameter int left_start_p     = 9,
  parameter int screen_left_p    = 0,
  parameter int screen_right_p   = 639,
  parameter int step_px_p        = 4,
  parameter int drop_px_p        = 16,
  parameter int land_y_p         = 320,
  parameter int frames_per_col_p = 4,
  parameter int min_period_p     = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  pause_i,
  input  logic                  frame_i,
  input  logic [num_cols_p-1:0] col_alive_i,
  output logic [X_OFF_W-1:0]    x_off_o,
  output logic [Y_OFF_W-1:0]    y_off_o,
  output logic                  dir_o,
  output logic                  step_o,
  output logic                  drop_o,
  output logic                  landed_o,
  output logic                  all_dead_o,
  output logic                  marching_o
);

  localparam int IDX_W      = (num_cols_p > 1) ? $clog2(num_cols_p) : 1;
  localparam int ACNT_W     = $clog2(num_cols_p + 1);
  localparam int PROD_MAX   = num_cols_p * frames_per_col_p;
  localparam int PERIOD_MAX = (PROD_MAX > min_period_p) ? PROD_MAX : min_period_p;
  localparam int CNT_W      = $clog2(PERIOD_MAX + 1);

  localparam logic signed [EDGE_W-1:0] LEFT_S   = EDGE_W'(left_start_p);
  localparam logic signed [EDGE_W-1:0] WIDTH_S  = EDGE_W'(col_width_p - 1);
  localparam logic signed [EDGE_W-1:0] STEP_S   = EDGE_W'(step_px_p);
  localparam logic signed [EDGE_W-1:0] SCR_L_S  = EDGE_W'(screen_left_p);
  localparam logic signed [EDGE_W-1:0] SCR_R_S  = EDGE_W'(screen_right_p);

  state_e                     state_q, state_d;
  logic signed [X_OFF_W-1:0]  x_off_q, x_off_d;
  logic        [Y_OFF_W-1:0]  y_off_q, y_off_d;
  logic                       dir_q, dir_d;
  logic        [CNT_W-1:0]    cnt_q, cnt_d;
  logic                       step_q, step_d;
  logic                       drop_q, drop_d;

  logic [IDX_W-1:0]  low_idx, high_idx;
  logic [ACNT_W-1:0] alive_cnt;
  logic              any_alive;

  alive_extent #(
    .num_cols_p (num_cols_p)
  ) u_extent (
    .col_alive_i (col_alive_i),
    .low_idx_o   (low_idx),
    .high_idx_o  (high_idx),
    .count_o     (alive_cnt),
    .any_o       (any_alive)
  );

  // Step period shrinks with the number of surviving columns, floored
  // at min_period_p so a lone column still moves at a sane rate.
  logic [31:0]      prod_full;
  logic [CNT_W-1:0] period;

  always_comb begin
    prod_full = 32'(alive_cnt) * 32'(frames_per_col_p);
    period    = (prod_full < 32'(min_period_p)) ? CNT_W'(min_period_p)
                                                : CNT_W'(prod_full);
  end

  // Signed screen-space edges of the outermost live columns.
  logic signed [EDGE_W-1:0] x_ext, low_px, high_px, left_edge, right_edge;
  logic                     hit_edge;

  always_comb begin
    x_ext      = EDGE_W'(x_off_q);
    low_px     = EDGE_W'(low_idx * col_pitch_p);
    high_px    = EDGE_W'(high_idx * col_pitch_p);
    left_edge  = LEFT_S + x_ext + low_px;
    right_edge = LEFT_S + x_ext + high_px + WIDTH_S;
    hit_edge   = dir_q ? ((right_edge + STEP_S) > SCR_R_S)
                       : ((left_edge - STEP_S) < SCR_L_S);
  end

  logic [Y_OFF_W:0] y_sum;
  assign y_sum = {1'b0, y_off_q} + (Y_OFF_W + 1)'(drop_px_p);

  // Next-state logic. In MARCH an empty formation outranks landing,
  // which outranks a tick. The counter test uses >= so a period that
  // shrinks mid-count fires on the next frame instead of wrapping.
  always_comb begin
    state_d = state_q;
    x_off_d = x_off_q;
    y_off_d = y_off_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    step_d  = 1'b0;
    drop_d  = 1'b0;
    unique case (state_q)
      MARCH: begin
        if (!any_alive) begin
          state_d = CLEARED;
        end else if (y_off_q >= Y_OFF_W'(land_y_p)) begin
          state_d = LANDED;
        end else if (frame_i && !pause_i) begin
          if (cnt_q >= period - CNT_W'(1)) begin
            cnt_d = '0;
            if (hit_edge) begin
              y_off_d = y_sum[Y_OFF_W] ? '1 : y_sum[Y_OFF_W-1:0];
              dir_d   = ~dir_q;
              drop_d  = 1'b1;
            end else begin
              x_off_d = dir_q ? x_off_q + X_OFF_W'(step_px_p)
                              : x_off_q - X_OFF_W'(step_px_p);
              step_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      IDLE, CLEARED, LANDED: begin
        if (start_i) begin
          state_d = MARCH;
          x_off_d = '0;
          y_off_d = '0;
          dir_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and offset registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      x_off_q <= '0;
      y_off_q <= '0;
      dir_q   <= 1'b1;
      cnt_q   <= '0;
      step_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_off_q <= x_off_d;
      y_off_q <= y_off_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      drop_q  <= drop_d;
    end
  end

  assign x_off_o    = x_off_q;
  assign y_off_o    = y_off_q;
  assign dir_o      = dir_q;
  assign step_o     = step_q;
  assign drop_o     = drop_q;
  assign landed_o   = (state_q == LANDED);
  assign all_dead_o = (state_q == CLEARED);
  assign marching_o = (state_q == MARCH);

endmodule

// File: tb/tb_enemy_formation_ctrl.sv
// tb_enemy_formation_ctrl
//   Self-checking bench: directed march/drop/pause/clear/land scenarios
//   followed by randomized stimulus, all compared each cycle against a
//   behavioural model of the formation rules.
module tb_enemy_formation_ctrl;

  localparam int NCOLS = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             pause = 1'b0;
  logic             frame = 1'b0;
  logic [NCOLS-1:0] alive = '0;
  logic [10:0]      xOff;
  logic [9:0]       yOff;
  logic             dir, step, drop, landed, allDead, marching;

  always #5 clk = ~clk;

  enemy_formation_ctrl dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .start_i     (start),
    .pause_i     (pause),
    .frame_i     (frame),
    .col_alive_i (alive),
    .x_off_o     (xOff),
    .y_off_o     (yOff),
    .dir_o       (dir),
    .step_o      (step),
    .drop_o      (drop),
    .landed_o    (landed),
    .all_dead_o  (allDead),
    .marching_o  (marching)
  );

  int checkCount = 0;
  int failCount  = 0;

  // Reference model state: 0 idle, 1 march, 2 cleared, 3 landed.
  int mState = 0;
  int mX = 0, mY = 0, mDir = 1, mCnt = 0, mStep = 0, mDrop = 0;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Advance the model by one clock using the formation rules directly.
  task automatic modelStep(input bit r, input bit s, input bit p, input bit f,
                           input logic [NCOLS-1:0] a);
    int period, lo, hi, leftEdge, rightEdge;
    mStep = 0;
    mDrop = 0;
    if (r) begin
      mState = 0; mX = 0; mY = 0; mDir = 1; mCnt = 0;
      return;
    end
    if (mState == 1) begin
      if (a == 0) begin
        mState = 2;
      end else if (mY >= 320) begin
        mState = 3;
      end else if (f && !p) begin
        period = $countones(a) * 4;
        if (period < 2) period = 2;
        if (mCnt >= period - 1) begin
          mCnt = 0;
          lo = -1;
          hi = -1;
          for (int i = 0; i < NCOLS; i++) begin
            if (a[i]) begin
              if (lo < 0) lo = i;
              hi = i;
            end
          end
          leftEdge  = 9 + mX + lo * 40;
          rightEdge = 9 + mX + hi * 40 + 23;
          if ((mDir == 1 && rightEdge + 4 > 639) || (mDir == 0 && leftEdge - 4 < 0)) begin
            mY    = (mY + 16 > 1023) ? 1023 : mY + 16;
            mDir  = 1 - mDir;
            mDrop = 1;
          end else begin
            mX    = (mDir == 1) ? mX + 4 : mX - 4;
            mStep = 1;
          end
        end else begin
          mCnt++;
        end
      end
    end else if (s) begin
      mState = 1; mX = 0; mY = 0; mDir = 1; mCnt = 0;
    end
  endtask

  // Drive one cycle of inputs, advance the model, then compare all outputs.
  task automatic applyStimulus(input bit r, input bit s, input bit p, input bit f,
                               input logic [NCOLS-1:0] a);
    reset = r; start = s; pause = p; frame = f; alive = a;
    modelStep(r, s, p, f, a);
    @(posedge clk);
    #1;
    checkOutput("x_off",    int'($signed(xOff)), mX);
    checkOutput("y_off",    int'(yOff), mY);
    checkOutput("dir",      int'(dir), mDir);
    checkOutput("step",     int'(step), mStep);
    checkOutput("drop",     int'(drop), mDrop);
    checkOutput("landed",   int'(landed), (mState == 3) ? 1 : 0);
    checkOutput("all_dead", int'(allDead), (mState == 2) ? 1 : 0);
    checkOutput("marching", int'(marching), (mState == 1) ? 1 : 0);
  endtask

  // Main sequence: directed scenarios, then random traffic.
  initial begin
    int seen;
    int drops;
    logic [NCOLS-1:0] ra;

    #2;
    applyStimulus(1, 0, 0, 0, 8'hFF);
    applyStimulus(1, 0, 0, 0, 8'hFF);
    checkOutput("reset_dir", int'(dir), 1);
    checkOutput("reset_x", int'($signed(xOff)), 0);

    // Full formation: period 32, first step on the 32nd frame.
    applyStimulus(0, 1, 0, 0, 8'hFF);
    repeat (31) applyStimulus(0, 0, 0, 1, 8'hFF);
    checkOutput("no_early_step_x", int'($signed(xOff)), 0);
    applyStimulus(0, 0, 0, 1, 8'hFF);
    checkOutput("first_step", int'(step), 1);
    checkOutput("first_step_x", int'($signed(xOff)), 4);

    // March to the right edge and drop.
    seen = 0;
    for (int i = 0; i < 3000 && seen == 0; i++) begin
      applyStimulus(0, 0, 0, 1, 8'hFF);
      if (drop) seen = 1;
    end
    checkOutput("drop_seen", seen, 1);
    checkOutput("drop_x", int'($signed(xOff)), 324);
    checkOutput("drop_y", int'(yOff), 16);
    checkOutput("drop_dir", int'(dir), 0);

    // Pause after 3 counted frames; frames during pause are lost.
    repeat (3) applyStimulus(0, 0, 0, 1, 8'hFF);
    repeat (10) applyStimulus(0, 0, 1, 1, 8'hFF);
    checkOutput("pause_x", int'($signed(xOff)), 324);
    repeat (28) applyStimulus(0, 0, 0, 1, 8'hFF);
    checkOutput("resume_wait_x", int'($signed(xOff)), 324);
    applyStimulus(0, 0, 0, 1, 8'hFF);
    checkOutput("resume_step_x", int'($signed(xOff)), 320);

    // Reset mid-march at x=100, start ignored while marching.
    applyStimulus(1, 0, 0, 0, 8'hFF);
    applyStimulus(0, 1, 0, 0, 8'hFF);
    seen = 0;
    for (int i = 0; i < 1200 && seen == 0; i++) begin
      applyStimulus(0, 0, 0, 1, 8'hFF);
      if ($signed(xOff) == 100) seen = 1;
    end
    checkOutput("reach_x100", seen, 1);
    applyStimulus(0, 1, 0, 0, 8'hFF);
    checkOutput("start_ignored_x", int'($signed(xOff)), 100);
    applyStimulus(1, 0, 0, 0, 8'hFF);
    checkOutput("midreset_x", int'($signed(xOff)), 0);
    checkOutput("midreset_marching", int'(marching), 0);

    // Single column 7: period 4; kill it on a tick cycle.
    applyStimulus(0, 1, 0, 0, 8'h80);
    repeat (4) applyStimulus(0, 0, 0, 1, 8'h80);
    checkOutput("single_step_x", int'($signed(xOff)), 4);
    repeat (3) applyStimulus(0, 0, 0, 1, 8'h80);
    applyStimulus(0, 0, 0, 1, 8'h00);
    checkOutput("cleared", int'(allDead), 1);
    checkOutput("cleared_no_step", int'(step), 0);
    checkOutput("cleared_x", int'($signed(xOff)), 4);

    // Restart from CLEARED with one column and march until 20 drops.
    applyStimulus(0, 1, 0, 0, 8'h01);
    drops = 0;
    for (int i = 0; i < 20000 && drops < 20; i++) begin
      applyStimulus(0, 0, 0, 1, 8'h01);
      if (drop) drops++;
    end
    checkOutput("twenty_drops", drops, 20);
    checkOutput("land_y", int'(yOff), 320);
    applyStimulus(0, 0, 0, 1, 8'h01);
    checkOutput("landed_next", int'(landed), 1);
    repeat (10) applyStimulus(0, 0, 0, 1, 8'h01);
    applyStimulus(0, 1, 0, 0, 8'h01);
    checkOutput("restart_x", int'($signed(xOff)), 0);
    checkOutput("restart_y", int'(yOff), 0);
    checkOutput("restart_marching", int'(marching), 1);

    // Randomized traffic.
    ra = 8'hFF;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(39, 0) == 0) ra = NCOLS'($urandom);
      if ($urandom_range(199, 0) == 0) ra = '0;
      applyStimulus($urandom_range(499, 0) == 0,
                    $urandom_range(49, 0) == 0,
                    $urandom_range(7, 0) == 0,
                    $urandom_range(1, 0) == 1,
                    ra);
      if (allDead && ra == 0) ra = 8'hFF;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
